// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM controller: command encodings, address
// field positions and the read/write sequencer state encoding.
package sdram_pkg;

  localparam logic [3:0] CMD_NOP    = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE = 4'b0011;
  localparam logic [3:0] CMD_READ   = 4'b0101;
  localparam logic [3:0] CMD_BSTOP  = 4'b0110;
  localparam logic [3:0] CMD_PRE    = 4'b0010;

  localparam int BANK_HI = 23;
  localparam int BANK_LO = 22;
  localparam int ROW_HI  = 21;
  localparam int ROW_LO  = 9;
  localparam int COL_HI  = 8;
  localparam int COL_LO  = 0;

  localparam logic [9:0] MAX_BURST = 10'd512;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_ACTIVE  = 3'd1;
  localparam state_t ST_TRCD    = 3'd2;
  localparam state_t ST_READ    = 3'd3;
  localparam state_t ST_RD_DATA = 3'd4;
  localparam state_t ST_PRE     = 3'd5;
  localparam state_t ST_TRP     = 3'd6;
  localparam state_t ST_END     = 3'd7;

endpackage

// File: rtl/sdram_read.sv
// Read-side command sequencer: ACTIVE, full-page READ, BURST STOP, PRECHARGE,
// with registered capture of the SDRAM data bus and a per-beat rd_ack strobe.
module sdram_read
  import sdram_pkg::*;
#(
  parameter int TRCD_CLK = 2,
  parameter int TRP_CLK  = 2,
  parameter int CL_CLK   = 3
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        init_end,
  input  logic        rd_en,
  input  logic [23:0] rd_addr,
  input  logic [9:0]  rd_burst_len,
  input  logic [15:0] sdram_dq,
  output logic        rd_ack,
  output logic        rd_end,
  output logic [3:0]  read_cmd,
  output logic [1:0]  read_ba,
  output logic [12:0] read_addr,
  output logic [15:0] rd_sdram_data
);

  localparam logic [9:0] CL        = 10'(CL_CLK);
  localparam logic [3:0] TRCD_LAST = 4'(TRCD_CLK - 2);
  localparam logic [3:0] TRP_LAST  = 4'(TRP_CLK - 2);

  function automatic logic [9:0] clamp_len(input logic [9:0] len);
    return (len > MAX_BURST) ? MAX_BURST : len;
  endfunction

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  wait_cnt;
  logic [9:0]  cyc_cnt;
  logic [9:0]  burst_len;
  logic [9:0]  req_len;
  logic [9:0]  last_cnt;
  logic [1:0]  bank;
  logic [12:0] row;
  logic [8:0]  col;
  logic        accept;

  assign req_len  = clamp_len(rd_burst_len);
  // END also accepts, so a held request restarts with no idle bubble.
  assign accept   = init_end && rd_en && (state == ST_IDLE || state == ST_END);
  assign last_cnt = burst_len + CL;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_END: begin
        if (accept) state_nxt = (req_len == 10'd0) ? ST_END : ST_ACTIVE;
        else        state_nxt = ST_IDLE;
      end
      ST_ACTIVE:  state_nxt = (TRCD_CLK > 1) ? ST_TRCD : ST_READ;
      ST_TRCD:    if (wait_cnt == TRCD_LAST) state_nxt = ST_READ;
      ST_READ:    state_nxt = ST_RD_DATA;
      ST_RD_DATA: if (cyc_cnt == last_cnt) state_nxt = ST_PRE;
      ST_PRE:     state_nxt = (TRP_CLK > 1) ? ST_TRP : ST_END;
      ST_TRP:     if (wait_cnt == TRP_LAST) state_nxt = ST_END;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state         <= ST_IDLE;
      wait_cnt      <= 4'd0;
      cyc_cnt       <= 10'd0;
      rd_sdram_data <= 16'd0;
    end else begin
      state         <= state_nxt;
      wait_cnt      <= (state_nxt != state) ? 4'd0 : wait_cnt + 4'd1;
      rd_sdram_data <= sdram_dq;
      // cyc_cnt equals the number of cycles elapsed since the READ command.
      if (state == ST_READ)         cyc_cnt <= 10'd1;
      else if (state == ST_RD_DATA) cyc_cnt <= cyc_cnt + 10'd1;
      else                          cyc_cnt <= 10'd0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (accept) begin
      bank      <= rd_addr[BANK_HI:BANK_LO];
      row       <= rd_addr[ROW_HI:ROW_LO];
      col       <= rd_addr[COL_HI:COL_LO];
      burst_len <= req_len;
    end
  end

  always_comb begin
    read_cmd  = CMD_NOP;
    read_ba   = 2'b11;
    read_addr = 13'h1fff;
    case (state)
      ST_ACTIVE: begin
        read_cmd  = CMD_ACTIVE;
        read_ba   = bank;
        read_addr = row;
      end
      ST_READ: begin
        read_cmd  = CMD_READ;
        read_ba   = bank;
        read_addr = {4'b0000, col};
      end
      ST_RD_DATA: if (cyc_cnt == burst_len) read_cmd = CMD_BSTOP;
      ST_PRE: begin
        read_cmd  = CMD_PRE;
        read_ba   = bank;
        read_addr = 13'h0000;
      end
      default: ;
    endcase
  end

  // Beat k is on the bus at READ+CL+k and leaves the capture register one cycle later.
  assign rd_ack = (state == ST_RD_DATA) && (cyc_cnt > CL) && (cyc_cnt <= last_cnt);
  assign rd_end = (state == ST_END);

endmodule
